// File: rtl/opto_signal_emulator.sv
// Emulated photoelectric code-disc tooth train with a per-revolution index gap.
// Optional glitch injection is built only when OPTO_GLITCH_INJ_EN is defined.
module opto_signal_emulator #(
  parameter int TOOTH_NUM = 100,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [CNT_WIDTH-1:0] i_high_cnt,
  input  logic [CNT_WIDTH-1:0] i_low_cnt,
  input  logic [CNT_WIDTH-1:0] i_gap_cnt,
  input  logic [3:0]           i_glitch_len,
  output logic                 o_opto_signal,
  output logic [7:0]           o_tooth_idx,
  output logic                 o_rev_pulse,
  output logic                 o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  localparam logic [7:0] LAST_IDX = 8'(TOOTH_NUM - 1);

  state_t               state;
  logic                 enable_p0;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] low_sh;
  logic [CNT_WIDTH-1:0] gap_sh;

  logic                 phase_end;
  logic                 to_gap;
  logic                 tooth_end;
  logic                 start_high;
  logic [7:0]           next_idx;
  logic                 high_next_lvl;

  function automatic logic [CNT_WIDTH-1:0] clamp1(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

`ifdef OPTO_GLITCH_INJ_EN
  logic [CNT_WIDTH-1:0] high_sh;
  logic [3:0]           glitch_sh;
  logic [CNT_WIDTH-1:0] high_pos_next;

  // True when clock 'pos' of a high phase of length 'hi' falls in the forced-low window.
  function automatic logic glitch_at(input logic [CNT_WIDTH-1:0] pos,
                                     input logic [CNT_WIDTH-1:0] hi,
                                     input logic [3:0]           g);
    logic [CNT_WIDTH:0] g_ext;
    logic [CNT_WIDTH:0] half;
    logic [CNT_WIDTH:0] lim;
    g_ext = (CNT_WIDTH+1)'(g);
    half  = {1'b0, hi} >> 1;
    lim   = half + g_ext;
    return (g != 4'd0) && ({1'b0, hi} > (g_ext << 1)) &&
           ({1'b0, pos} >= half) && ({1'b0, pos} < lim);
  endfunction

  assign high_pos_next = high_sh - cnt + CNT_WIDTH'(1);
  assign high_next_lvl = ~glitch_at(high_pos_next, high_sh, glitch_sh);
`else
  logic unused_glitch;
  assign unused_glitch = ^i_glitch_len;
  assign high_next_lvl = 1'b1;
`endif

  always_comb begin
    phase_end  = (cnt == CNT_WIDTH'(1));
    to_gap     = 1'b0;
    tooth_end  = 1'b0;
    start_high = 1'b0;
    next_idx   = 8'd0;
    if (state == S_LOW && phase_end && o_tooth_idx == LAST_IDX && gap_sh != '0)
      to_gap = 1'b1;
    if ((state == S_LOW && phase_end && !to_gap) || (state == S_GAP && phase_end))
      tooth_end = 1'b1;
    if (enable_p0 && (state == S_IDLE || tooth_end))
      start_high = 1'b1;
    if (state != S_IDLE && o_tooth_idx != LAST_IDX)
      next_idx = o_tooth_idx + 8'd1;
  end

  // Shadow settings: captured once per tooth so mid-tooth input changes wait for the next tooth.
  always_ff @(posedge i_clk) begin
    if (start_high) begin
      low_sh <= clamp1(i_low_cnt);
      gap_sh <= i_gap_cnt;
`ifdef OPTO_GLITCH_INJ_EN
      high_sh   <= clamp1(i_high_cnt);
      glitch_sh <= i_glitch_len;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      enable_p0     <= 1'b0;
      cnt           <= '0;
      o_opto_signal <= 1'b0;
      o_tooth_idx   <= 8'd0;
      o_rev_pulse   <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      enable_p0   <= i_enable;
      o_rev_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          o_opto_signal <= 1'b0;
          o_tooth_idx   <= 8'd0;
          o_busy        <= 1'b0;
          if (start_high) begin
            state         <= S_HIGH;
            cnt           <= clamp1(i_high_cnt);
            o_opto_signal <= 1'b1;
            o_rev_pulse   <= 1'b1;
            o_busy        <= 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            state         <= S_LOW;
            cnt           <= low_sh;
            o_opto_signal <= 1'b0;
          end else begin
            cnt           <= cnt - CNT_WIDTH'(1);
            o_opto_signal <= high_next_lvl;
          end
        end
        S_LOW, S_GAP: begin
          if (to_gap) begin
            state <= S_GAP;
            cnt   <= gap_sh;
          end else if (tooth_end) begin
            if (start_high) begin
              state         <= S_HIGH;
              cnt           <= clamp1(i_high_cnt);
              o_opto_signal <= 1'b1;
              o_tooth_idx   <= next_idx;
              o_rev_pulse   <= (next_idx == 8'd0);
            end else begin
              state       <= S_IDLE;
              cnt         <= '0;
              o_tooth_idx <= 8'd0;
              o_busy      <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opto_signal_emulator.sv
// Directed scoreboard bench: expected per-clock outputs are generated from tooth
// parameters (high/low/gap/glitch) and compared clock by clock at the falling edge.
module tb_opto_signal_emulator;

  localparam int TN = 4;
  localparam int CW = 16;

`ifdef OPTO_GLITCH_INJ_EN
  localparam bit GLITCH_BUILD = 1'b1;
`else
  localparam bit GLITCH_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       opto;
    logic [7:0] idx;
    logic       rev;
    logic       busy;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] hi_cnt, lo_cnt, gap_cnt;
  logic [3:0]    glitch_len;
  logic          opto, rev, busy;
  logic [7:0]    idx;

  obs_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  opto_signal_emulator #(.TOOTH_NUM(TN), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .i_high_cnt   (hi_cnt),
    .i_low_cnt    (lo_cnt),
    .i_gap_cnt    (gap_cnt),
    .i_glitch_len (glitch_len),
    .o_opto_signal(opto),
    .o_tooth_idx  (idx),
    .o_rev_pulse  (rev),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required completion within 500us");
    $fatal(1, "bench timeout");
  end

  function automatic obs_t mk(input logic o, input int i, input logic r, input logic b);
    obs_t t;
    t.opto = o; t.idx = 8'(i); t.rev = r; t.busy = b;
    return t;
  endfunction

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) q.push_back(mk(1'b0, 0, 1'b0, 1'b0));
  endtask

  task automatic push_tooth(input int ti, input int h, input int l, input int gp, input int g);
    int  hc, lc;
    bit  gl;
    logic lvl;
    hc = (h == 0) ? 1 : h;
    lc = (l == 0) ? 1 : l;
    gl = GLITCH_BUILD && (g != 0) && (hc > 2 * g);
    for (int p = 0; p < hc; p++) begin
      lvl = !(gl && p >= hc / 2 && p < hc / 2 + g);
      q.push_back(mk(lvl, ti, (p == 0) && (ti == 0), 1'b1));
    end
    for (int p = 0; p < lc; p++) q.push_back(mk(1'b0, ti, 1'b0, 1'b1));
    if (ti == TN - 1)
      for (int p = 0; p < gp; p++) q.push_back(mk(1'b0, ti, 1'b0, 1'b1));
  endtask

  task automatic compare(input string tag, input obs_t got, input obs_t exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed opto=%0b idx=%0d rev=%0b busy=%0b, expected opto=%0b idx=%0d rev=%0b busy=%0b",
             tag, got.opto, got.idx, got.rev, got.busy, exp.opto, exp.idx, exp.rev, exp.busy);
    end
  endtask

  task automatic check_cycles(input string tag, input int n);
    obs_t exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: observed empty scoreboard, required a pending expectation", tag);
      end else begin
        exp = q.pop_front();
        compare(tag, mk(opto, int'(idx), rev, busy), exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    hi_cnt = '0; lo_cnt = '0; gap_cnt = '0; glitch_len = '0;
    repeat (2) @(negedge clk);
    compare("reset_opto", mk(opto, 0, 1'b0, 1'b0), mk(1'b0, 0, 1'b0, 1'b0));
    compare("reset_idx",  mk(1'b0, int'(idx), 1'b0, 1'b0), mk(1'b0, 0, 1'b0, 1'b0));
    compare("reset_rev",  mk(1'b0, 0, rev, 1'b0), mk(1'b0, 0, 1'b0, 1'b0));
    compare("reset_busy", mk(1'b0, 0, 1'b0, busy), mk(1'b0, 0, 1'b0, 1'b0));
    rst_n = 1'b1;
    push_idle(2);
    check_cycles("idle", 2);

    // Plain tooth train, 8-clock period, 32-clock revolution
    en = 1'b1; hi_cnt = 16'd5; lo_cnt = 16'd3;
    push_idle(1);
    for (int t = 0; t < TN; t++) push_tooth(t, 5, 3, 0, 0);
    check_cycles("rev_nogap", 33);

    // Short enable dropout inside a tooth is invisible
    push_tooth(0, 5, 3, 0, 0);
    check_cycles("blip", 3);
    en = 1'b0;
    check_cycles("blip", 2);
    en = 1'b1;
    check_cycles("blip", 3);

    // Disable two clocks into tooth 1 high: tooth completes, then idle
    push_tooth(1, 5, 3, 0, 0);
    check_cycles("stop", 2);
    en = 1'b0;
    check_cycles("stop", 6);
    push_idle(3);
    check_cycles("stop_idle", 3);

    // Re-enable with index gap: restarts at tooth 0, revolution 42 clocks
    en = 1'b1; gap_cnt = 16'd10;
    push_idle(1);
    for (int t = 0; t < TN; t++) push_tooth(t, 5, 3, 10, 0);
    push_tooth(0, 5, 3, 10, 0);
    check_cycles("rev_gap", 51);
    for (int t = 1; t < TN; t++) push_tooth(t, 5, 3, 10, 0);
    check_cycles("pre_rst", 28);

    // Asynchronous reset four clocks into the gap
    rst_n = 1'b0;
    #1;
    compare("rst_mid_gap", mk(opto, int'(idx), rev, busy), mk(1'b0, 0, 1'b0, 1'b0));
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(1);
    push_tooth(0, 5, 3, 10, 0);
    check_cycles("post_rst", 4);
    hi_cnt = '0; lo_cnt = '0; gap_cnt = '0;
    check_cycles("post_rst", 5);

    // Zero widths clamp to 1/1: toggle every clock
    for (int t = 1; t < TN; t++) push_tooth(t, 0, 0, 0, 0);
    push_tooth(0, 0, 0, 0, 0);
    check_cycles("zero_width", 7);
    hi_cnt = 16'd20; lo_cnt = 16'd3; glitch_len = 4'd3;
    check_cycles("zero_width", 1);

    // Glitch window at clocks 10..12 of a 20-clock high (macro builds only)
    push_tooth(1, 20, 3, 0, 3);
    push_tooth(2, 20, 3, 0, 3);
    check_cycles("glitch20", 45);
    hi_cnt = 16'd6;
    check_cycles("glitch20", 1);

    // high=6 with glitch_len=3 never glitches
    push_tooth(3, 6, 3, 0, 3);
    push_tooth(0, 6, 3, 0, 3);
    check_cycles("glitch6", 11);
    en = 1'b0;
    check_cycles("glitch6", 7);
    push_idle(2);
    check_cycles("final_idle", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
